npu_dispatch: RTL

NPU_DISPATCH -- requirements
Module: npu_dispatch

---
 rtl/npu_dispatch.sv | 101 ++++++++++
 1 files changed

// File: rtl/npu_dispatch.sv
// Dispatches custom-0 NPU instructions: it stalls decode, hands the command to the NPU,
// waits for completion or a timeout, and then issues a single writeback.
module npu_dispatch #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [6:0]      id_funct7,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    output logic            stall_o,
    output logic            npu_cmd_valid,
    input  logic            npu_cmd_ready,
    output logic [1:0]      npu_cmd_op,
    output logic [XLEN-1:0] npu_cmd_src,
    output logic [XLEN-1:0] npu_cmd_dst,
    input  logic            npu_done,
    input  logic [XLEN-1:0] npu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_o,
    output logic            timeout_o
);

    localparam logic [6:0] OPCODE_CUSTOM0     = 7'b0001011;
    localparam logic [6:0] FUNCT7_MATRIX_MUL  = 7'b0000001;
    localparam logic [6:0] FUNCT7_CONVOLUTION = 7'b0000010;
    localparam logic [1:0] NPU_OP_NONE        = 2'b00;
    localparam logic [1:0] NPU_OP_MATMUL      = 2'b01;
    localparam logic [1:0] NPU_OP_CONV        = 2'b10;
    localparam int         CW                 = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt;
    logic            is_custom, funct_ok, accept, illegal_det, timeout_hit;

    assign is_custom   = id_valid && (id_opcode == OPCODE_CUSTOM0);
    assign funct_ok    = (id_funct7 == FUNCT7_MATRIX_MUL) || (id_funct7 == FUNCT7_CONVOLUTION);
    assign accept      = (state == IDLE) && is_custom && funct_ok;
    assign illegal_det = (state == IDLE) && is_custom && !funct_ok;
    // A done pulse on the final count still wins over the timeout.
    assign timeout_hit = (state == WAIT) && !npu_done && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (npu_cmd_ready) state_nxt = WAIT;
            WAIT:    if (npu_done || timeout_hit) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_o       = (state != IDLE) || accept;
        npu_cmd_valid = (state == ISSUE);
        npu_cmd_op    = npu_cmd_valid ? op_q : NPU_OP_NONE;
        wb_valid      = (state == WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= NPU_OP_NONE;
            wb_rd       <= '0;
            npu_cmd_src <= '0;
            npu_cmd_dst <= '0;
            wb_data     <= '0;
            cnt         <= '0;
            illegal_o   <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            illegal_o <= illegal_det;
            timeout_o <= timeout_hit;
            if (accept) begin
                op_q        <= (id_funct7 == FUNCT7_MATRIX_MUL) ? NPU_OP_MATMUL : NPU_OP_CONV;
                wb_rd       <= id_rd;
                npu_cmd_src <= id_rs1_val;
                npu_cmd_dst <= id_rs2_val;
            end
            if (state == ISSUE && npu_cmd_ready) cnt <= '0;
            else if (state == WAIT && !npu_done) cnt <= cnt + CW'(1);
            if (state == WAIT && npu_done) wb_data <= npu_result;
            else if (timeout_hit)          wb_data <= '1;
        end
    end

endmodule
